// File: rtl/snx_mem_arbiter.sv
// snx_mem_arbiter: shares the single-port SNX data RAM between r0 (CPU data
// port) and r1 (loader/DMA/debug port). Commands are registered one cycle
// after the handshake; read data returns two cycles after it, steered to its
// owner by a tagged valid pipeline.
// Optional build macro SNX_ARB_PRIO_EN: fixed priority to r0 with an
// anti-starvation counter for r1. Without it, arbitration is round-robin.
module snx_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          r0_req,
  input  logic          r0_write,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_write,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out
);

  // ---- stage p0: arbitration / handshake ----
  logic          gnt0_p0;
  logic          gnt1_p0;
  logic          xfer_p0;
  logic          wr_p0;
  logic          own_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] data_p0;

`ifdef SNX_ARB_PRIO_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          r1_force;

  // r0 wins whenever it asks, unless r1 has waited through STARVE_LIMIT r0 grants
  always_comb begin
    r1_force = r1_req && (starve_cnt >= CW'(STARVE_LIMIT));
    gnt0_p0  = r0_req && !r1_force;
    gnt1_p0  = r1_req && (!r0_req || r1_force);
  end

  // Count r0 grants taken while r1 is waiting; any other outcome clears it
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      starve_cnt <= '0;
    end else if (r0_ack && r1_req) begin
      starve_cnt <= starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  // 1 means r1 took the most recent transfer, so r0 wins the next tie
  logic last_grant;

  // On a tie, grant the requester that did not win last time
  always_comb begin
    gnt0_p0 = r0_req && (!r1_req || last_grant);
    gnt1_p0 = r1_req && (!r0_req || !last_grant);
  end

  // Remember the winner of every completed handshake
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      last_grant <= 1'b1;
    end else if (r0_ack) begin
      last_grant <= 1'b0;
    end else if (r1_ack) begin
      last_grant <= 1'b1;
    end
  end
`endif

  // Gate grants with reset and mux the winning command toward the issue stage
  always_comb begin
    r0_ack  = gnt0_p0 && !p_reset;
    r1_ack  = gnt1_p0 && !p_reset;
    xfer_p0 = r0_ack || r1_ack;
    own_p0  = r1_ack;
    wr_p0   = r1_ack ? r1_write : r0_write;
    addr_p0 = r1_ack ? r1_addr  : r0_addr;
    data_p0 = r1_ack ? r1_wdata : r0_wdata;
  end

  // ---- stage p1: registered RAM command ----
  logic          rd_vld_p1;
  logic          wr_vld_p1;
  logic          own_p1;
  logic [AW-1:0] addr_p1;
  logic [DW-1:0] data_p1;

  // Register the winner's command; address/data hold when nothing transfers
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      rd_vld_p1 <= 1'b0;
      wr_vld_p1 <= 1'b0;
      own_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else begin
      rd_vld_p1 <= xfer_p0 && !wr_p0;
      wr_vld_p1 <= xfer_p0 && wr_p0;
      if (xfer_p0) begin
        own_p1  <= own_p0;
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign mem_read  = rd_vld_p1;
  assign mem_write = wr_vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_in    = data_p1;

  // ---- stage p2: read return, RAM output valid this cycle ----
  logic vld_p2;
  logic own_p2;

  // Carry the read tag alongside the RAM latency; reset drops reads in flight
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      vld_p2 <= 1'b0;
      own_p2 <= 1'b0;
    end else begin
      vld_p2 <= rd_vld_p1;
      own_p2 <= own_p1;
    end
  end

  assign r0_rvalid = vld_p2 && !own_p2;
  assign r1_rvalid = vld_p2 && own_p2;
  assign r0_rdata  = mem_out;
  assign r1_rdata  = mem_out;

endmodule
